// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX operand, forwarding and EX/MEM result signals of the execute stage.
interface ex_stage_if;
    logic        id_ex_valid;
    logic [31:0] id_ex_rs1_data;
    logic [31:0] id_ex_rs2_data;
    logic [31:0] id_ex_imm;
    logic        id_ex_alu_src;
    logic [4:0]  id_ex_alu_op;
    logic [4:0]  id_ex_rd;
    logic        id_ex_RegWrite;
    logic [1:0]  forwardA;
    logic [1:0]  forwardB;
    logic [31:0] wb_data;
    logic        ex_mem_valid;
    logic [31:0] ex_mem_alu_result;
    logic [31:0] ex_mem_rs2_data;
    logic [4:0]  ex_mem_rd;
    logic        ex_mem_RegWrite;
    logic        ex_stall;
    modport master (
        output id_ex_valid, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm, id_ex_alu_src,
               id_ex_alu_op, id_ex_rd, id_ex_RegWrite, forwardA, forwardB, wb_data,
        input  ex_mem_valid, ex_mem_alu_result, ex_mem_rs2_data, ex_mem_rd, ex_mem_RegWrite, ex_stall
    );
    modport slave (
        input  id_ex_valid, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm, id_ex_alu_src,
               id_ex_alu_op, id_ex_rd, id_ex_RegWrite, forwardA, forwardB, wb_data,
        output ex_mem_valid, ex_mem_alu_result, ex_mem_rs2_data, ex_mem_rd, ex_mem_RegWrite, ex_stall
    );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: RV32IM execute stage with single-cycle ALU, iterative mul/div and the EX/MEM register.
module ex_stage (
    input  logic       clk,
    input  logic       rst,
    ex_stage_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2;
    logic [1:0]  r_state;
    logic [4:0]  r_cnt, r_op, r_rd;
    logic        r_rw, r_sa, r_sb, r_bz;
    logic [31:0] r_d, r_fwdb;
    logic [63:0] r_acc, r_m;
    logic [31:0] w_opa, w_fwdb, w_opb, w_base, w_mag_a, w_mag_b, w_q, w_rem, w_mres, w_sub;
    logic [63:0] w_prod;
    logic [32:0] w_top;
    logic        w_is_m, w_start, w_sa, w_sb, w_mul, w_ge, w_idle;

    assign w_opa   = bus.forwardA == 2'b01 ? bus.wb_data : bus.forwardA == 2'b10 ? bus.ex_mem_alu_result : bus.id_ex_rs1_data;
    assign w_fwdb  = bus.forwardB == 2'b01 ? bus.wb_data : bus.forwardB == 2'b10 ? bus.ex_mem_alu_result : bus.id_ex_rs2_data;
    assign w_opb   = bus.id_ex_alu_src ? bus.id_ex_imm : w_fwdb;
    assign w_idle  = r_state == S_IDLE;
    assign w_is_m  = bus.id_ex_alu_op >= 5'd10 && bus.id_ex_alu_op <= 5'd17;
    assign w_start = w_idle && bus.id_ex_valid && w_is_m;
    assign bus.ex_stall = !rst && (w_start || r_state == S_BUSY);
    // MUL/MULH/DIV/REM treat both operands as signed, MULHSU only the first.
    assign w_sa    = w_opa[31] && (bus.id_ex_alu_op inside {5'd10, 5'd11, 5'd12, 5'd14, 5'd16});
    assign w_sb    = w_opb[31] && (bus.id_ex_alu_op inside {5'd10, 5'd11, 5'd14, 5'd16});
    assign w_mag_a = w_sa ? -w_opa : w_opa;
    assign w_mag_b = w_sb ? -w_opb : w_opb;
    assign w_mul   = r_op < 5'd14;
    assign w_top   = r_acc[63:31];
    assign w_ge    = w_top >= {1'b0, r_d};
    assign w_sub   = w_top[31:0] - r_d;
    assign w_prod  = (r_sa ^ r_sb) ? -r_acc : r_acc;
    assign w_q     = r_bz ? 32'hFFFF_FFFF : (r_sa ^ r_sb) ? -r_acc[31:0] : r_acc[31:0];
    assign w_rem   = r_sa ? -r_acc[63:32] : r_acc[63:32];
    assign w_mres  = r_op == 5'd10 ? w_prod[31:0] : w_mul ? w_prod[63:32] : r_op < 5'd16 ? w_q : w_rem;

    always_comb begin
        w_base = 32'd0;
        case (bus.id_ex_alu_op)
            5'd0: w_base = w_opa + w_opb;
            5'd1: w_base = w_opa - w_opb;
            5'd2: w_base = w_opa << w_opb[4:0];
            5'd3: w_base = {31'd0, $signed(w_opa) < $signed(w_opb)};
            5'd4: w_base = {31'd0, w_opa < w_opb};
            5'd5: w_base = w_opa ^ w_opb;
            5'd6: w_base = w_opa >> w_opb[4:0];
            5'd7: w_base = $signed(w_opa) >>> w_opb[4:0];
            5'd8: w_base = w_opa | w_opb;
            5'd9: w_base = w_opa & w_opb;
            default: w_base = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_rd    <= '0;
            r_rw    <= 1'b0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_bz    <= 1'b0;
            r_d     <= '0;
            r_fwdb  <= '0;
            r_acc   <= '0;
            r_m     <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_start) begin
                    r_state <= S_BUSY;
                    r_cnt   <= '0;
                    r_op    <= bus.id_ex_alu_op;
                    r_rd    <= bus.id_ex_rd;
                    r_rw    <= bus.id_ex_RegWrite;
                    r_fwdb  <= w_fwdb;
                    r_sa    <= w_sa;
                    r_sb    <= w_sb;
                    r_bz    <= w_opb == 32'd0;
                    r_d     <= w_mag_b;
                    r_m     <= {32'd0, w_mag_a};
                    r_acc   <= bus.id_ex_alu_op < 5'd14 ? 64'd0 : {32'd0, w_mag_a};
                end
                S_BUSY: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) r_state <= S_DONE;
                    if (w_mul) begin
                        if (r_d[0]) r_acc <= r_acc + r_m;
                        r_m <= r_m << 1;
                        r_d <= r_d >> 1;
                    end else begin
                        // r_acc = {partial remainder, dividend bits / quotient bits}
                        r_acc <= w_ge ? {w_sub, r_acc[30:0], 1'b1} : {r_acc[62:0], 1'b0};
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.ex_mem_valid      <= 1'b0;
            bus.ex_mem_alu_result <= '0;
            bus.ex_mem_rs2_data   <= '0;
            bus.ex_mem_rd         <= '0;
            bus.ex_mem_RegWrite   <= 1'b0;
        end else begin
            bus.ex_mem_valid      <= r_state == S_DONE || (w_idle && bus.id_ex_valid && !w_is_m);
            bus.ex_mem_RegWrite   <= r_state == S_DONE ? r_rw : w_idle && bus.id_ex_valid && !w_is_m && bus.id_ex_RegWrite;
            bus.ex_mem_alu_result <= r_state == S_DONE ? w_mres : w_base;
            bus.ex_mem_rs2_data   <= r_state == S_DONE ? r_fwdb : w_fwdb;
            bus.ex_mem_rd         <= r_state == S_DONE ? r_rd : bus.id_ex_rd;
        end
    end
endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage RV32IM pipeline, sitting directly downstream of the forwarding unit and the ID/EX register. It consumes `forwardA`/`forwardB`, selects ALU operands from register-file data, the EX/MEM result or the MEM/WB write-back value, and executes RV32I ALU operations in one cycle and RV32M multiply/divide operations iteratively. It also owns the EX/MEM pipeline register and raises `ex_stall` to freeze IF/ID/EX while a multi-cycle operation runs.

## Interface
- XLEN, 32, datapath width. Only 32 is supported.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- id_ex_valid  in  1  ID/EX holds a real instruction
- id_ex_rs1_data, id_ex_rs2_data  in  32  register-file read data
- id_ex_imm  in  32  sign-extended immediate
- id_ex_alu_src  in  1  operand B select: 0 = forwarded rs2, 1 = imm
- id_ex_alu_op  in  5  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14 DIV, 15 DIVU, 16 REM, 17 REMU; 18–31 produce result 0
- id_ex_rd  in  5  destination register
- id_ex_RegWrite  in  1  destination write enable
- forwardA, forwardB  in  2  forwarding selects: 00 regfile, 01 wb_data, 10 ex_mem_alu_result, 11 treated as 00
- wb_data  in  32  MEM/WB write-back value
- ex_mem_valid  out  1  EX/MEM holds a real instruction
- ex_mem_alu_result  out  32  registered result; also the forwarding source for select 10
- ex_mem_rs2_data  out  32  forwarded rs2 value, used as store data
- ex_mem_rd  out  5  registered destination
- ex_mem_RegWrite  out  1  equals id_ex_RegWrite & id_ex_valid, as registered
- ex_stall  out  1  combinational; holds PC, IF/ID and ID/EX

## Operation
- Operand A is the forwarded rs1. fwdB is the forwarded rs2. Operand B is `alu_src ? imm : fwdB`.
- Shifts use `opB[4:0]`. SLT is signed; SLTU is unsigned.
- Arithmetic is modulo 2^32.
- FSM states: IDLE, BUSY, DONE. All instructions with op < 10 and all bubbles are handled in IDLE.
- **IDLE with a valid op in 10–17:**
  - Assert `ex_stall`.
  - Latch opA, opB, op, rd, RegWrite and fwdB into internal registers. Forwarded values must be captured here, because `wb_data` changes while the pipeline drains.
  - Go to BUSY with cnt = 0.
- **BUSY:**
  - Multiply: radix-2 shift-add on magnitudes into a 64-bit product; signs are fixed up at the end.
  - Divide: radix-2 restoring divide on magnitudes.
  - `ex_stall` = 1.
  - When cnt = 31, go to DONE.
- **DONE:**
  - `ex_stall` = 0.
  - On this edge EX/MEM captures the sign-corrected result, and the FSM returns to IDLE.
- **Result selection:**
  - MUL returns the low 32 bits of the product.
  - MULH, MULHSU and MULHU return the high 32 bits with the signedness implied by their names.
- **Divide special cases:**
  - Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF returns 0x80000000; REM of the same operands returns 0.
  - Special cases keep the full latency; there is no early exit.
- **EX/MEM in IDLE:** load every edge from the current operation.
- **EX/MEM while `ex_stall` = 1:** load a bubble (`ex_mem_valid` = 0, `ex_mem_RegWrite` = 0). Other fields are don't-care.
- `id_ex_valid` = 0 in IDLE loads a bubble and does not start the FSM.

## Timing
- Reset values:
  - All EX/MEM outputs are 0.
  - FSM is IDLE, cnt = 0, `ex_stall` = 0.
- Reset is asynchronous. Asserting it mid-BUSY aborts the operation with no result and drops `ex_stall` immediately.
- Base op presented in cycle t appears on EX/MEM after edge t.
- M op presented in cycle t:
  - `ex_stall` is high in cycles t through t+32 (33 cycles).
  - The result appears after edge t+33.
  - The next ID/EX instruction is accepted in cycle t+34.
- Back-to-back M ops: the second op is seen in IDLE in cycle t+34 and starts immediately. There are no idle bubbles between operations other than the stall bubbles.

## Test plan
- ADD with forwardA = 10: previous result 5, rs2 = 7 -> `ex_mem_alu_result` = 12 one cycle later, `ex_mem_valid` = 1.
- SRA: rs1 = 0x80000000, imm = 0x24, alu_src = 1 -> shift by 4 -> 0xF8000000. SLTU of 1 vs 0xFFFFFFFF -> 1.
- MULH with -2 × 3, forwardB = 01, wb_data = 3:
  - `ex_stall` is high for exactly 33 cycles.
  - Result 0xFFFFFFFF.
  - `wb_data` is changed to 9 mid-operation with no effect.
- DIV by 0 -> 0xFFFFFFFF; REM 7 / 0 -> 7; DIV 0x80000000 / -1 -> 0x80000000; REM of the same operands -> 0.
- Reset asserted in BUSY cycle 10 -> `ex_stall` drops without waiting for a clock, outputs are 0, and a following ADD completes in 1 cycle.
- Bubble with `id_ex_valid` = 0 and RegWrite = 1 -> `ex_mem_RegWrite` = 0; forward select 11 behaves as 00.
